// File: rtl/dwconv_ofmap_writer.sv
// ---------------------------------------------------------------------------
// dwconv_ofmap_writer
//
// Output stage of the 4-lane depthwise-conv pipeline. Each valid beat carries
// four signed int8 lanes and a (cnt, pos) tag. The lanes are packed into one
// 32-bit word, queued in a small show-ahead FIFO together with the target
// address BASE_ADDR + cnt*POS_NUM + pos, and written to the output feature-map
// SRAM one word per accepted handshake. Once CNT_NUM*POS_NUM words have been
// written the layer is complete and the block parks in DONE until restarted.
//
// Ports
//   clk, rst_b        clock, asynchronous active-low reset
//   start             1-cycle pulse: flush FIFO, clear counter and err, enter RUN
//   in_valid          beat valid (already qualified by upstream enable)
//   cnt_in, pos_in    channel-group and position tags of the beat
//   data0..data3      signed int8 lanes, data0 lands in bits [7:0]
//   stall             combinational back-pressure to upstream
//   mem_wr_en         SRAM write request
//   mem_wr_addr       SRAM word address of the head entry
//   mem_wr_data       packed head entry {data3,data2,data1,data0}
//   mem_wr_ready      SRAM accepts the write this cycle
//   busy, done        state is RUN / state is DONE
//   err               sticky: out-of-range tag or FIFO overflow seen
// ---------------------------------------------------------------------------
module dwconv_ofmap_writer #(
    parameter int CNT_NUM    = 32,
    parameter int POS_NUM    = 9,
    parameter int ADDR_W     = 9,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic              in_valid,
    input  logic [4:0]        cnt_in,
    input  logic [3:0]        pos_in,
    input  logic signed [7:0] data0,
    input  logic signed [7:0] data1,
    input  logic signed [7:0] data2,
    input  logic signed [7:0] data3,
    output logic              stall,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    input  logic              mem_wr_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TOTAL = CNT_NUM * POS_NUM;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int EW    = ADDR_W + 32;

    localparam logic [CW-1:0] TOTAL_C   = CW'(TOTAL);
    localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]   STALL_LVL = (PW + 1)'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       fifo_cnt;
    logic [CW-1:0]     wr_cnt;
    logic              err_q;

    logic              run;
    logic              wr_en_int;
    logic              pop;
    logic              push;
    logic              tags_ok;
    logic              has_room;
    logic              err_set;
    logic              layer_end;
    logic              flush;
    logic [ADDR_W-1:0] entry_addr;
    logic [31:0]       entry_data;
    logic [EW-1:0]     head;

    // Address arithmetic is done in ADDR_W bits so it wraps modulo the SRAM size.
    assign entry_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt_in) * ADDR_W'(POS_NUM) + ADDR_W'(pos_in);
    assign entry_data = {data3, data2, data1, data0};

    assign run       = (state == RUN);
    assign tags_ok   = (32'(cnt_in) < CNT_NUM) && (32'(pos_in) < POS_NUM);
    assign wr_en_int = run && (fifo_cnt != '0);
    assign pop       = wr_en_int && mem_wr_ready;
    // A full FIFO can still take a beat when the head leaves in the same cycle.
    assign has_room  = (fifo_cnt < DEPTH_C) || pop;
    // start wins over everything: a beat arriving with start is discarded by the flush.
    assign push      = in_valid && run && !start && tags_ok && has_room;
    assign err_set   = in_valid && run && !(tags_ok && has_room);
    // The write accepted this cycle may be the last one of the layer.
    assign layer_end = run && ((wr_cnt == TOTAL_C) || (pop && (wr_cnt == TOTAL_C - 1'b1)));
    // Leaving RUN discards any leftover (duplicate) entries.
    assign flush     = start || (state_nxt != RUN);

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start restarts the layer from any state.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     if (layer_end) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage holds {address, packed lanes}; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {entry_addr, entry_data};
    end

    // Completed-write counter, restarted by start.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)     wr_cnt <= '0;
        else if (start) wr_cnt <= '0;
        else if (pop)   wr_cnt <= wr_cnt + 1'b1;
    end

    // Sticky error flag, cleared only by start or reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)       err_q <= 1'b0;
        else if (start)   err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end

    // Head entry drives the SRAM port; zeroed while no write is requested.
    assign head        = fifo_mem[rd_ptr];
    assign mem_wr_en   = wr_en_int;
    assign mem_wr_addr = wr_en_int ? head[EW-1:32] : '0;
    assign mem_wr_data = wr_en_int ? head[31:0] : '0;

    assign stall = run && (fifo_cnt >= STALL_LVL);
    assign busy  = run;
    assign done  = (state == DONE);
    assign err   = err_q;

endmodule

// File: tb/tb_dwconv_ofmap_writer.sv
// ---------------------------------------------------------------------------
// tb_dwconv_ofmap_writer
//
// Drives randomized beats into two instances of the writer (BASE_ADDR 0 and
// 500) and compares their outputs every cycle against a queue-based model of
// the layer: beats accepted in RUN are appended, each SRAM handshake removes
// the oldest one, and the layer ends after CNT_NUM*POS_NUM writes.
// ---------------------------------------------------------------------------
module tb_dwconv_ofmap_writer;

    localparam int LAYER_WORDS = 32 * 9;

    logic              clk;
    logic              rst_b;
    logic              start;
    logic              in_valid;
    logic [4:0]        cnt_in;
    logic [3:0]        pos_in;
    logic signed [7:0] data0, data1, data2, data3;
    logic              mem_wr_ready;

    logic              stall, mem_wr_en, busy, done, err;
    logic [8:0]        mem_wr_addr;
    logic [31:0]       mem_wr_data;

    logic              b_stall, b_mem_wr_en, b_busy, b_done, b_err;
    logic [8:0]        b_mem_wr_addr;
    logic [31:0]       b_mem_wr_data;

    dwconv_ofmap_writer dut (
        .clk(clk), .rst_b(rst_b), .start(start), .in_valid(in_valid),
        .cnt_in(cnt_in), .pos_in(pos_in),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .stall(stall), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready),
        .busy(busy), .done(done), .err(err)
    );

    dwconv_ofmap_writer #(.BASE_ADDR(500)) dut_b (
        .clk(clk), .rst_b(rst_b), .start(start), .in_valid(in_valid),
        .cnt_in(cnt_in), .pos_in(pos_in),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .stall(b_stall), .mem_wr_en(b_mem_wr_en), .mem_wr_addr(b_mem_wr_addr),
        .mem_wr_data(b_mem_wr_data), .mem_wr_ready(mem_wr_ready),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of the layer.
    typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
    typedef struct {
        int          raw_addr;
        logic [31:0] data;
    } entry_t;

    mstate_t m_state;
    entry_t  m_q[$];
    int      m_written;
    bit      m_err;
    int      obs_writes;

    int checks;
    int failures;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // One clock cycle: check outputs against the model at the falling edge,
    // drive the next beat (respecting stall), then advance the model to the
    // state the next rising edge will produce.
    task automatic applyStimulus(input bit st, input bit want, input int c, input int p,
                                 input bit rdy, input logic [31:0] lanes, output bit accepted);
        bit     exp_run;
        bit     exp_en;
        bit     do_pop;
        int     sz;
        entry_t e;
        @(negedge clk);
        exp_run = (m_state == M_RUN);
        exp_en  = exp_run && (m_q.size() != 0);
        checkOutput("busy", busy, exp_run);
        checkOutput("done", done, m_state == M_DONE);
        checkOutput("err", err, m_err);
        checkOutput("stall", stall, exp_run && (m_q.size() >= 3));
        checkOutput("mem_wr_en", mem_wr_en, exp_en);
        checkOutput("b_flags", {b_busy, b_done, b_err, b_stall, b_mem_wr_en},
                    {exp_run, m_state == M_DONE, m_err, exp_run && (m_q.size() >= 3), exp_en});
        if (exp_en) begin
            checkOutput("addr", mem_wr_addr, m_q[0].raw_addr % 512);
            checkOutput("data", mem_wr_data, m_q[0].data);
            checkOutput("b_addr", b_mem_wr_addr, (m_q[0].raw_addr + 500) % 512);
            checkOutput("b_data", b_mem_wr_data, m_q[0].data);
        end
        if (!st && mem_wr_en && rdy) obs_writes++;

        start        = st;
        mem_wr_ready = rdy;
        in_valid     = want && !stall;
        cnt_in       = c[4:0];
        pos_in       = p[3:0];
        data0        = lanes[7:0];
        data1        = lanes[15:8];
        data2        = lanes[23:16];
        data3        = lanes[31:24];

        accepted = 1'b0;
        if (st) begin
            m_state   = M_RUN;
            m_q.delete();
            m_written = 0;
            m_err     = 1'b0;
        end else if (m_state == M_RUN) begin
            sz     = m_q.size();
            do_pop = (sz != 0) && rdy;
            if (do_pop) begin
                void'(m_q.pop_front());
                m_written++;
            end
            if (in_valid) begin
                if (c < 32 && p < 9 && (sz < 4 || do_pop)) begin
                    e.raw_addr = c * 9 + p;
                    e.data     = {data3, data2, data1, data0};
                    m_q.push_back(e);
                    accepted = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (m_written == LAYER_WORDS) begin
                m_state = M_DONE;
                m_q.delete();
            end
        end
    endtask

    task automatic idleCycle(input bit rdy);
        bit acc;
        applyStimulus(1'b0, 1'b0, 0, 0, rdy, $urandom(), acc);
    endtask

    task automatic startLayer();
        bit acc;
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, $urandom(), acc);
    endtask

    // Feed the remaining beats of a full layer in tag order until the model
    // sees the layer complete, within a fixed cycle budget.
    task automatic runLayer(input int first, input bit rand_ready, input int base_writes);
        int idx;
        int budget;
        bit acc;
        bit rdy;
        idx    = first;
        budget = 0;
        while (m_state != M_DONE && budget < 3000) begin
            rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            applyStimulus(1'b0, idx < LAYER_WORDS, idx / 9, idx % 9, rdy, $urandom(), acc);
            if (acc) idx++;
            budget++;
        end
        checkOutput("layer_complete", m_state == M_DONE, 1);
        checkOutput("layer_writes", obs_writes - base_writes, LAYER_WORDS);
    endtask

    initial begin
        bit acc;
        int idx;
        int held;
        int base;
        checks     = 0;
        failures   = 0;
        obs_writes = 0;
        m_state    = M_IDLE;
        m_written  = 0;
        m_err      = 1'b0;

        rst_b        = 1'b0;
        start        = 1'b0;
        in_valid     = 1'b0;
        cnt_in       = '0;
        pos_in       = '0;
        {data3, data2, data1, data0} = '0;
        mem_wr_ready = 1'b0;

        #12;
        checkOutput("reset_outputs", {stall, mem_wr_en, busy, done, err}, 5'b0);
        checkOutput("reset_addr", mem_wr_addr, 0);
        checkOutput("reset_data", mem_wr_data, 0);
        @(negedge clk);
        rst_b = 1'b1;

        // Beats while IDLE are ignored, even with bad tags.
        applyStimulus(1'b0, 1'b1, 3, 4, 1'b1, $urandom(), acc);
        applyStimulus(1'b0, 1'b1, 31, 9, 1'b1, $urandom(), acc);
        idleCycle(1'b1);

        // Full layer, SRAM always ready, with a known packing example first.
        startLayer();
        base = obs_writes;
        applyStimulus(1'b0, 1'b1, 0, 0, 1'b1, 32'h04030201, acc);
        @(posedge clk);
        #1;
        checkOutput("pack_example", mem_wr_data, 32'h04030201);
        checkOutput("latency_1clk", mem_wr_en, 1);
        runLayer(1, 1'b0, base);

        // Beats in DONE are ignored and done is held.
        applyStimulus(1'b0, 1'b1, 2, 2, 1'b1, $urandom(), acc);
        applyStimulus(1'b0, 1'b1, 31, 9, 1'b1, $urandom(), acc);
        idleCycle(1'b1);

        // SRAM stalled for 10 cycles under continuous input: only 3 beats fit.
        startLayer();
        base = obs_writes;
        idx  = 0;
        held = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, idx / 9, idx % 9, 1'b0, $urandom(), acc);
            if (acc) begin
                idx++;
                held++;
            end
        end
        checkOutput("held_entries", held, 3);
        runLayer(idx, 1'b0, base);

        // Address wrap on the BASE_ADDR=500 instance, then an out-of-range tag.
        startLayer();
        applyStimulus(1'b0, 1'b1, 5, 8, 1'b0, $urandom(), acc);
        @(posedge clk);
        #1;
        checkOutput("base500_addr", b_mem_wr_addr, 9'd41);
        checkOutput("base0_addr", mem_wr_addr, 9'd53);
        applyStimulus(1'b0, 1'b1, 31, 9, 1'b0, $urandom(), acc);
        @(posedge clk);
        #1;
        checkOutput("err_bad_tag", err, 1);
        checkOutput("bad_tag_not_queued", mem_wr_addr, 9'd53);
        idleCycle(1'b1);
        idleCycle(1'b1);
        startLayer();
        @(posedge clk);
        #1;
        checkOutput("err_cleared", err, 0);

        // Random traffic with occasional out-of-range positions and duplicates.
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 31),
                          $urandom_range(0, 9), $urandom_range(0, 2) != 0, $urandom(), acc);
        end

        // Restart mid-layer with a pending, unacknowledged write.
        startLayer();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, i, i, 1'b0, $urandom(), acc);
        end
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, $urandom(), acc);
        @(posedge clk);
        #1;
        checkOutput("en_after_start", mem_wr_en, 0);
        checkOutput("busy_after_start", busy, 1);
        base = obs_writes;
        runLayer(0, 1'b1, base);

        // Asynchronous reset while a write is being requested.
        startLayer();
        applyStimulus(1'b0, 1'b1, 7, 3, 1'b0, $urandom(), acc);
        applyStimulus(1'b0, 1'b1, 7, 4, 1'b0, $urandom(), acc);
        idleCycle(1'b1);
        #2;
        checkOutput("pre_reset_en", mem_wr_en, 1);
        rst_b = 1'b0;
        #1;
        checkOutput("async_reset_flags", {stall, mem_wr_en, busy, done, err}, 5'b0);
        checkOutput("async_reset_addr", mem_wr_addr, 0);
        checkOutput("async_reset_data", mem_wr_data, 0);
        m_state = M_IDLE;
        m_q.delete();
        m_written = 0;
        m_err     = 1'b0;
        in_valid  = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        applyStimulus(1'b0, 1'b1, 1, 1, 1'b1, $urandom(), acc);
        idleCycle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
